// File: rtl/sargantana_icache_pkg.sv
// Shared definitions for the icache data array: refill FSM states and
// line geometry derived from the default cache configuration.
package sargantana_icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2
  } fill_state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_LINE_WIDTH  = 256;
  localparam int DEF_BEAT_WIDTH  = 64;
  localparam int DEF_FETCH_WIDTH = 128;

  localparam int BEATS          = DEF_LINE_WIDTH / DEF_BEAT_WIDTH;
  localparam int WORDS_PER_LINE = DEF_LINE_WIDTH / DEF_FETCH_WIDTH;
  localparam int BEAT_CNT_W     = clog2_min1(BEATS);
  localparam int OFFSET_W       = clog2_min1(WORDS_PER_LINE);

endpackage

// File: rtl/sargantana_icache_data_array_if.sv
// Controller-facing bus of the icache data array: fetch read port,
// hit-way response select and the beat-wise refill channel.
interface sargantana_icache_data_array_if
  import sargantana_icache_pkg::*;
#(
  parameter int NUM_WAYS    = 4,
  parameter int LINE_WIDTH  = DEF_LINE_WIDTH,
  parameter int BEAT_WIDTH  = DEF_BEAT_WIDTH,
  parameter int FETCH_WIDTH = DEF_FETCH_WIDTH,
  parameter int ADDR_WIDTH  = 6
);
  localparam int WORD_OFF_W = clog2_min1(LINE_WIDTH / FETCH_WIDTH);

  logic                   req_valid_i;
  logic                   req_ready_o;
  logic [ADDR_WIDTH-1:0]  req_index_i;
  logic [WORD_OFF_W-1:0]  req_word_i;
  logic [NUM_WAYS-1:0]    rd_way_i;
  logic                   rd_valid_o;
  logic [FETCH_WIDTH-1:0] rd_data_o;
  logic                   refill_valid_i;
  logic                   refill_ready_o;
  logic [BEAT_WIDTH-1:0]  refill_data_i;
  logic [ADDR_WIDTH-1:0]  refill_index_i;
  logic [NUM_WAYS-1:0]    refill_way_i;
  logic                   refill_abort_i;
  logic                   refill_done_o;

  modport master (
    output req_valid_i, req_index_i, req_word_i, rd_way_i,
    output refill_valid_i, refill_data_i, refill_index_i, refill_way_i, refill_abort_i,
    input  req_ready_o, rd_valid_o, rd_data_o, refill_ready_o, refill_done_o
  );

  modport slave (
    input  req_valid_i, req_index_i, req_word_i, rd_way_i,
    input  refill_valid_i, refill_data_i, refill_index_i, refill_way_i, refill_abort_i,
    output req_ready_o, rd_valid_o, rd_data_o, refill_ready_o, refill_done_o
  );

endinterface

// File: rtl/sargantana_icache_way.sv
// One way of the data array: a single-port line SRAM with registered read
// data. Requests are ignored while the macro is held in reset.
module sargantana_icache_way #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [LINE_WIDTH-1:0] wdata_i,
  output logic [LINE_WIDTH-1:0] rdata_o
);

  logic [LINE_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Single-port access: write the full line, or read it into rdata_o.
  always_ff @(posedge clk_i) begin
    if (rstn_i && req_i) begin
      if (we_i) mem[addr_i] <= wdata_i;
      else      rdata_o     <= mem[addr_i];
    end
  end

endmodule

// File: rtl/sargantana_icache_data_array.sv
// Icache data array: NUM_WAYS line SRAMs read in parallel, fetch word
// chosen from the hit way one cycle later, and a refill path that assembles
// beats into a line buffer before one full-line write to the victim way.
module sargantana_icache_data_array
  import sargantana_icache_pkg::*;
#(
  parameter int NUM_WAYS    = 4,
  parameter int LINE_WIDTH  = DEF_LINE_WIDTH,
  parameter int BEAT_WIDTH  = DEF_BEAT_WIDTH,
  parameter int FETCH_WIDTH = DEF_FETCH_WIDTH,
  parameter int ADDR_WIDTH  = 6
) (
  input  logic clk_i,
  input  logic rst_i,
  sargantana_icache_data_array_if.slave bus
);

  localparam int N_BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int N_WORDS = LINE_WIDTH / FETCH_WIDTH;
  localparam int CNT_W   = clog2_min1(N_BEATS);
  localparam int OFF_W   = clog2_min1(N_WORDS);

  fill_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [LINE_WIDTH-1:0]  line_buf_q;
  logic [ADDR_WIDTH-1:0]  fill_idx_q;
  logic [NUM_WAYS-1:0]    fill_way_q;
  logic                   is_write;
  logic                   read_acc;
  logic                   beat_acc;
  logic                   beat_first;
  logic                   vld_p1;
  logic [OFF_W-1:0]       word_p1;
  logic [NUM_WAYS-1:0]    way_req;
  logic [NUM_WAYS-1:0]    way_we;
  logic [ADDR_WIDTH-1:0]  way_addr;
  logic [LINE_WIDTH-1:0]  way_rdata [NUM_WAYS];
  logic [FETCH_WIDTH-1:0] rd_data;

  assign is_write           = (state_q == ST_WRITE);
  assign read_acc           = bus.req_valid_i && !is_write;
  assign bus.req_ready_o    = !is_write;
  assign bus.refill_ready_o = !is_write;
  assign bus.refill_done_o  = is_write;

  // Refill FSM next state: collect beats, abort drops the partial line,
  // WRITE lasts exactly one cycle and ignores abort.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    beat_acc   = 1'b0;
    beat_first = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.refill_valid_i && !bus.refill_abort_i) begin
          beat_acc   = 1'b1;
          beat_first = 1'b1;
          if (N_BEATS == 1) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_FILL;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_FILL: begin
        if (bus.refill_abort_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (bus.refill_valid_i) begin
          beat_acc = 1'b1;
          if (cnt_q == CNT_W'(N_BEATS - 1)) state_d = ST_WRITE;
          else                              cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control state: FSM, beat counter and response valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      vld_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_p1  <= read_acc;
    end
  end

  // ---- stage p0 -> p1: line buffer, refill target and word offset ----
  always_ff @(posedge clk_i) begin
    if (beat_acc) line_buf_q[int'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH] <= bus.refill_data_i;
    if (beat_first) begin
      fill_idx_q <= bus.refill_index_i;
      fill_way_q <= bus.refill_way_i;
    end
    if (read_acc) word_p1 <= bus.req_word_i;
  end

  assign way_we   = is_write ? fill_way_q : '0;
  assign way_req  = {NUM_WAYS{read_acc}} | way_we;
  assign way_addr = is_write ? fill_idx_q : bus.req_index_i;

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    sargantana_icache_way #(
      .LINE_WIDTH (LINE_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_way (
      .clk_i   (clk_i),
      .rstn_i  (~rst_i),
      .req_i   (way_req[w]),
      .we_i    (way_we[w]),
      .addr_i  (way_addr),
      .wdata_i (line_buf_q),
      .rdata_o (way_rdata[w])
    );
  end

  // ---- stage p1: way/word select, OR of hit ways, zero when not valid ----
  always_comb begin
    rd_data = '0;
    if (vld_p1) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (bus.rd_way_i[w]) rd_data = rd_data | way_rdata[w][int'(word_p1)*FETCH_WIDTH +: FETCH_WIDTH];
      end
    end
  end

  assign bus.rd_valid_o = vld_p1;
  assign bus.rd_data_o  = rd_data;

endmodule

// File: tb/tb_sargantana_icache_data_array.sv
// Directed bench for the icache data array with the default 4-way,
// 4-beat, 2-word-per-line configuration.
module tb_sargantana_icache_data_array;
  import sargantana_icache_pkg::*;

  localparam int NW = 4;
  localparam int LW = 256;
  localparam int BW = 64;
  localparam int FW = 128;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sargantana_icache_data_array_if #(
    .NUM_WAYS(NW), .LINE_WIDTH(LW), .BEAT_WIDTH(BW), .FETCH_WIDTH(FW), .ADDR_WIDTH(AW)
  ) bus ();

  sargantana_icache_data_array #(
    .NUM_WAYS(NW), .LINE_WIDTH(LW), .BEAT_WIDTH(BW), .FETCH_WIDTH(FW), .ADDR_WIDTH(AW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] mk_line(input int n);
    logic [LW-1:0] l;
    for (int b = 0; b < BEATS; b++)
      l[b*BW +: BW] = {32'hC0DE_0000 + 32'(n*16 + b), 32'h1234_0000 + 32'(n)};
    return l;
  endfunction

  function automatic logic [FW-1:0] word_of(input logic [LW-1:0] l, input int w);
    return l[w*FW +: FW];
  endfunction

  // Four beats on consecutive cycles; returns in the WRITE cycle.
  // Index/way are scrambled after the first beat to show they are latched.
  task automatic send_beats(input logic [AW-1:0] idx, input logic [NW-1:0] way, input logic [LW-1:0] line);
    for (int b = 0; b < BEATS; b++) begin
      bus.refill_valid_i = 1'b1;
      bus.refill_data_i  = line[b*BW +: BW];
      bus.refill_index_i = idx ^ AW'(b);
      bus.refill_way_i   = (b == 0) ? way : ~way;
      check("refill_ready during fill", bus.refill_ready_o, 1'b1);
      step();
      if (b < BEATS - 1) check("done early", bus.refill_done_o, 1'b0);
    end
    bus.refill_valid_i = 1'b0;
    check("done in write", bus.refill_done_o, 1'b1);
    check("refill_ready in write", bus.refill_ready_o, 1'b0);
    check("req_ready in write", bus.req_ready_o, 1'b0);
  endtask

  task automatic finish_write();
    step();
    check("done after write", bus.refill_done_o, 1'b0);
    check("refill_ready after write", bus.refill_ready_o, 1'b1);
  endtask

  task automatic read_word(input logic [AW-1:0] idx, input logic [OFFSET_W-1:0] word,
                           input logic [NW-1:0] way, output logic [FW-1:0] data);
    bus.req_valid_i = 1'b1;
    bus.req_index_i = idx;
    bus.req_word_i  = word;
    #1;
    check("req_ready for read", bus.req_ready_o, 1'b1);
    step();
    bus.req_valid_i = 1'b0;
    bus.rd_way_i    = way;
    #1;
    check("rd_valid", bus.rd_valid_o, 1'b1);
    data = bus.rd_data_o;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] d;
    logic [LW-1:0] la, lc, lx;

    rst = 1'b1;
    bus.req_valid_i = 1'b0; bus.req_index_i = '0; bus.req_word_i = '0; bus.rd_way_i = '0;
    bus.refill_valid_i = 1'b0; bus.refill_data_i = '0; bus.refill_index_i = '0;
    bus.refill_way_i = '0; bus.refill_abort_i = 1'b0;
    step(); step();
    check("reset rd_valid", bus.rd_valid_o, 1'b0);
    check("reset rd_data", bus.rd_data_o, '0);
    check("reset done", bus.refill_done_o, 1'b0);
    check("reset req_ready", bus.req_ready_o, 1'b1);
    check("reset refill_ready", bus.refill_ready_o, 1'b1);
    rst = 1'b0;
    step();

    // Refill set 5 way 1 with beats A..D, read both words back.
    send_beats(6'd5, 4'b0010, {64'hD, 64'hC, 64'hB, 64'hA});
    finish_write();
    read_word(6'd5, 1'b1, 4'b0010, d);
    check("set5 word1", d, 128'h0000000000000000D_000000000000000C >> 0);
    bus.rd_way_i = '0;
    read_word(6'd5, 1'b0, 4'b0010, d);
    check("set5 word0", d, {64'hB, 64'hA});
    bus.rd_way_i = '0;
    step();
    check("rd_valid idle", bus.rd_valid_o, 1'b0);

    // All four ways of set 0, then back-to-back reads over the ways.
    for (int w = 0; w < NW; w++) begin
      send_beats(6'd0, NW'(1 << w), mk_line(10 + w));
      finish_write();
    end
    for (int i = 0; i <= NW; i++) begin
      if (i < NW) begin
        bus.req_valid_i = 1'b1;
        bus.req_index_i = 6'd0;
        bus.req_word_i  = OFFSET_W'(i % 2);
      end else begin
        bus.req_valid_i = 1'b0;
      end
      if (i > 0) begin
        bus.rd_way_i = NW'(1 << (i - 1));
        #1;
        check("b2b rd_valid", bus.rd_valid_o, 1'b1);
        check("b2b data", bus.rd_data_o, word_of(mk_line(10 + i - 1), (i - 1) % 2));
      end
      step();
    end
    bus.rd_way_i = '0;

    // Read request during WRITE stalls one cycle and sees the new line.
    lx = mk_line(9);
    send_beats(6'd7, 4'b0100, lx);
    bus.req_valid_i = 1'b1;
    bus.req_index_i = 6'd7;
    bus.req_word_i  = 1'b1;
    #1;
    check("req_ready blocked in write", bus.req_ready_o, 1'b0);
    step();
    check("no response for blocked read", bus.rd_valid_o, 1'b0);
    check("req_ready after write", bus.req_ready_o, 1'b1);
    step();
    bus.req_valid_i = 1'b0;
    bus.rd_way_i    = 4'b0100;
    #1;
    check("stalled read valid", bus.rd_valid_o, 1'b1);
    check("stalled read data", bus.rd_data_o, word_of(lx, 1));
    bus.rd_way_i = '0;
    step();

    // Two beats, abort with a beat, idle abort with a beat, then a full line.
    for (int b = 0; b < 2; b++) begin
      bus.refill_valid_i = 1'b1;
      bus.refill_data_i  = 64'hDEAD_0000_0000_0000 | 64'(b);
      bus.refill_index_i = 6'd3;
      bus.refill_way_i   = 4'b0001;
      step();
    end
    bus.refill_abort_i = 1'b1;
    bus.refill_data_i  = 64'hBAD0_BAD0_BAD0_BAD0;
    check("refill_ready with abort", bus.refill_ready_o, 1'b1);
    step();
    check("no done after fill abort", bus.refill_done_o, 1'b0);
    bus.refill_data_i = 64'hBAD1_BAD1_BAD1_BAD1;
    step();
    check("no done after idle abort", bus.refill_done_o, 1'b0);
    bus.refill_abort_i = 1'b0;
    bus.refill_valid_i = 1'b0;
    lx = mk_line(23);
    send_beats(6'd3, 4'b0001, lx);
    finish_write();
    read_word(6'd3, 1'b0, 4'b0001, d);
    check("set3 word0", d, word_of(lx, 0));
    bus.rd_way_i = '0;
    read_word(6'd3, 1'b1, 4'b0001, d);
    check("set3 word1", d, word_of(lx, 1));
    bus.rd_way_i = '0;
    step();

    // Reset after three beats: no commit, old line survives.
    la = mk_line(40);
    send_beats(6'd6, 4'b1000, la);
    finish_write();
    lx = mk_line(41);
    for (int b = 0; b < 3; b++) begin
      bus.refill_valid_i = 1'b1;
      bus.refill_data_i  = lx[b*BW +: BW];
      bus.refill_index_i = 6'd6;
      bus.refill_way_i   = 4'b1000;
      step();
    end
    bus.refill_valid_i = 1'b0;
    bus.req_valid_i    = 1'b1;
    bus.req_index_i    = 6'd6;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.rd_way_i    = 4'b1000;
    #1;
    check("post-reset rd_valid", bus.rd_valid_o, 1'b0);
    check("post-reset rd_data", bus.rd_data_o, '0);
    check("post-reset done", bus.refill_done_o, 1'b0);
    check("post-reset req_ready", bus.req_ready_o, 1'b1);
    check("post-reset refill_ready", bus.refill_ready_o, 1'b1);
    bus.rd_way_i = '0;
    step();
    check("no done after reset", bus.refill_done_o, 1'b0);
    read_word(6'd6, 1'b0, 4'b1000, d);
    check("set6 word0 kept", d, word_of(la, 0));
    bus.rd_way_i = '0;
    read_word(6'd6, 1'b1, 4'b1000, d);
    check("set6 word1 kept", d, word_of(la, 1));
    bus.rd_way_i = '0;
    lc = mk_line(42);
    send_beats(6'd6, 4'b1000, lc);
    finish_write();
    read_word(6'd6, 1'b1, 4'b1000, d);
    check("set6 refill after reset", d, word_of(lc, 1));

    // No hit way selects nothing.
    bus.rd_way_i = '0;
    read_word(6'd6, 1'b0, 4'b0000, d);
    check("no-way data", d, '0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
